// File: rtl/mx_exp_expand.sv
`default_nettype none
// ============================================================================
//  Module      : mx_exp_expand
//  Description : Receive-side MX shared-exponent expansion. Captures one MX
//                block (shared E8M0 scale plus LENGTH biased element
//                exponents) and streams the reconstructed absolute biased
//                exponent of each element, one per cycle, under valid/ready.
//  Ports       : i_clk / i_rst_n        clock, async active-low reset
//                i_valid / o_ready      block input handshake
//                i_scale, i_exps        shared scale and element exponents
//                o_valid / i_ready      element output handshake
//                o_exp, o_nan           reconstructed exponent, NaN-block flag
//                o_idx, o_last          element index, last-element marker
//  Revision    : 1.0  initial release
// ============================================================================
module mx_exp_expand #(
  parameter int WIDTH   = 8,
  parameter int E_WIDTH = 4,
  parameter int E_BIAS  = 7,
  parameter int LENGTH  = 32,
  localparam int IDX_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_scale,
  input  logic [E_WIDTH-1:0] i_exps [LENGTH],
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_exp,
  output logic               o_nan,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_last
);

  // Two guard bits: one for the carry of scale + element exponent, one sign
  // bit so the bias subtraction can go negative without wrapping.
  localparam int SUM_W = WIDTH + 2;
  localparam logic signed [SUM_W-1:0] C_BIAS = SUM_W'(E_BIAS);
  // Largest finite code; the all-ones code is reserved for NaN.
  localparam logic signed [SUM_W-1:0] C_MAX  = SUM_W'((1 << WIDTH) - 2);
  localparam logic [IDX_W-1:0]        C_LAST = IDX_W'(LENGTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WIDTH-1:0]     scale_q;
  logic [E_WIDTH-1:0]   exps_q [LENGTH];

  logic                 w_accept;
  logic                 w_last;
  logic                 w_nan;
  logic [E_WIDTH-1:0]   w_elem;
  logic signed [SUM_W-1:0] w_sum;

  assign o_valid  = (state_q == ST_STREAM);
  assign w_last   = (idx_q == C_LAST);
  assign o_last   = w_last;
  assign o_idx    = idx_q;

  // A new block may be taken while idle, or in the same cycle the final
  // element of the current block is consumed (zero-bubble back-to-back).
  assign o_ready  = (state_q == ST_IDLE) || (o_valid && i_ready && w_last);
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      scale_q <= '0;
      for (int k = 0; k < LENGTH; k++) begin
        exps_q[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        scale_q <= i_scale;
        exps_q  <= i_exps;
        idx_q   <= '0;
        state_q <= ST_STREAM;
      end else if ((state_q == ST_STREAM) && i_ready) begin
        if (w_last) begin
          state_q <= ST_IDLE;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign w_nan  = &scale_q;
  assign o_nan  = w_nan;
  assign w_elem = exps_q[idx_q];
  assign w_sum  = $signed({2'b00, scale_q}) + $signed(SUM_W'(w_elem)) - C_BIAS;

  always_comb begin
    o_exp = '0;
    if (!w_nan) begin
      if (w_sum < 0) begin
        o_exp = '0;
      end else if (w_sum > C_MAX) begin
        o_exp = C_MAX[WIDTH-1:0];
      end else begin
        o_exp = w_sum[WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mx_exp_expand.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mx_exp_expand
//  Description : Self-checking bench for mx_exp_expand. A driver issues MX
//                blocks and pushes the expected element stream into a queue;
//                an independent monitor pops and compares on each output
//                handshake and checks that stalled outputs hold steady.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mx_exp_expand;

  localparam int WIDTH   = 8;
  localparam int E_WIDTH = 4;
  localparam int E_BIAS  = 7;
  localparam int LENGTH  = 32;
  localparam int IDX_W   = 5;

  typedef struct {
    int exp_v;
    int nan_v;
    int idx_v;
    int last_v;
  } elem_t;

  logic               clk;
  logic               rst_n;
  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_scale;
  logic [E_WIDTH-1:0] i_exps [LENGTH];
  logic               o_valid;
  logic               i_ready;
  logic [WIDTH-1:0]   o_exp;
  logic               o_nan;
  logic [IDX_W-1:0]   o_idx;
  logic               o_last;

  mx_exp_expand #(
    .WIDTH  (WIDTH),
    .E_WIDTH(E_WIDTH),
    .E_BIAS (E_BIAS),
    .LENGTH (LENGTH)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_scale(i_scale),
    .i_exps (i_exps),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_exp  (o_exp),
    .o_nan  (o_nan),
    .o_idx  (o_idx),
    .o_last (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    n_pops   = 0;
  int    valid_cycles = 0;
  int    ready_mode = 0;     // 0: always ready, 1: random ~50% backpressure
  int    acc_cyc  = 0;       // cycle index of the most recent accepted block
  elem_t sb [$];

  int               nxt_scale;
  logic [E_WIDTH-1:0] nxt_exps [LENGTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: absolute exponent = scale + element - bias, clamped to the
  // finite range [0, 2^WIDTH-2]; a NaN-scale block yields 0 everywhere.
  function automatic int ref_exp(input int sc, input int e);
    int s;
    if (sc == (1 << WIDTH) - 1) return 0;
    s = sc + e - E_BIAS;
    if (s < 0) return 0;
    if (s > (1 << WIDTH) - 2) return (1 << WIDTH) - 2;
    return s;
  endfunction

  // Ready generator
  always @(negedge clk) begin
    if (ready_mode != 0) i_ready = ($urandom % 2) == 1;
    else                 i_ready = 1'b1;
  end

  // Monitor: compares every handshake, checks hold-while-stalled.
  int   prev_stall = 0;
  int   prev_exp, prev_idx, prev_nan;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (o_valid) valid_cycles++;
      if (prev_stall != 0) begin
        chk("stall_valid", int'(o_valid), 1);
        chk("stall_exp", int'(o_exp), prev_exp);
        chk("stall_idx", int'(o_idx), prev_idx);
        chk("stall_nan", int'(o_nan), prev_nan);
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          elem_t e;
          e = sb.pop_front();
          chk("exp", int'(o_exp), e.exp_v);
          chk("nan", int'(o_nan), e.nan_v);
          chk("idx", int'(o_idx), e.idx_v);
          chk("last", int'(o_last), e.last_v);
        end
        n_pops++;
      end
      prev_stall = (o_valid && !i_ready) ? 1 : 0;
      prev_exp   = int'(o_exp);
      prev_idx   = int'(o_idx);
      prev_nan   = int'(o_nan);
    end
  end

  // Drive nxt_* as a block; returns just after the accepting edge.
  task automatic send_block();
    int waited;
    @(negedge clk);
    i_valid = 1'b1;
    i_scale = nxt_scale[WIDTH-1:0];
    for (int k = 0; k < LENGTH; k++) i_exps[k] = nxt_exps[k];
    waited = 0;
    forever begin
      #1;
      if (o_ready) begin
        acc_cyc = cyc;
        for (int k = 0; k < LENGTH; k++) begin
          elem_t e;
          e.exp_v  = ref_exp(nxt_scale, int'(nxt_exps[k]));
          e.nan_v  = (nxt_scale == (1 << WIDTH) - 1) ? 1 : 0;
          e.idx_v  = k;
          e.last_v = (k == LENGTH - 1) ? 1 : 0;
          sb.push_back(e);
        end
        @(posedge clk);
        return;
      end
      waited++;
      if (waited > 500) begin
        chk("accept_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    i_valid = 1'b0;
    i_scale = '1;            // later input changes must be ignored
    for (int k = 0; k < LENGTH; k++) i_exps[k] = 4'hF;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int b1;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_scale = '0;
    for (int k = 0; k < LENGTH; k++) i_exps[k] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_exp", int'(o_exp), 0);
    chk("rst_nan", int'(o_nan), 0);
    chk("rst_idx", int'(o_idx), 0);
    chk("rst_last", int'(o_last), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", int'(o_ready), 1);

    // 1: single block, scale 127, exps k%16
    valid_cycles = 0;
    nxt_scale = 127;
    for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'(k % 16);
    send_block();
    go_idle();
    wait_drain();
    chk("t1_valid_cycles", valid_cycles, 32);

    // 2: back-to-back, i_valid held
    valid_cycles = 0;
    nxt_scale = 100;
    for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'($urandom % 16);
    send_block();
    b1 = acc_cyc;
    nxt_scale = 140;
    for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'($urandom % 16);
    send_block();
    chk("t2_accept_gap", acc_cyc - b1, 32);
    go_idle();
    wait_drain();
    chk("t2_valid_cycles", valid_cycles, 64);

    // 4: saturation and underflow
    nxt_scale = 254;
    for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'd15;
    send_block();
    nxt_scale = 0;
    for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'd0;
    send_block();
    go_idle();
    wait_drain();

    // 5: NaN block
    nxt_scale = 255;
    for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'($urandom % 16);
    send_block();
    go_idle();
    wait_drain();

    // 3: random blocks with backpressure and idle gaps
    ready_mode = 1;
    for (int b = 0; b < 8; b++) begin
      nxt_scale = (b == 5) ? 255 : int'($urandom_range(0, 255));
      for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'($urandom % 16);
      send_block();
      if (($urandom % 2) == 1) go_idle();
    end
    go_idle();
    wait_drain();
    ready_mode = 0;

    // 6: reset at element 10
    nxt_scale = 130;
    for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'($urandom % 16);
    send_block();
    go_idle();
    begin
      int n;
      n = 0;
      while (!(o_valid && o_idx == 5'd10) && n < 200) begin
        @(negedge clk);
        #2;
        n++;
      end
      chk("t6_reach_idx10", int'(o_idx), 10);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(o_valid), 0);
    chk("t6_async_idx", int'(o_idx), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    chk("t6_held_valid", int'(o_valid), 0);
    rst_n = 1'b1;
    #1;
    chk("t6_ready_after", int'(o_ready), 1);
    nxt_scale = 60;
    for (int k = 0; k < LENGTH; k++) nxt_exps[k] = 4'($urandom % 16);
    send_block();
    go_idle();
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
